// File: rtl/pong_pkg.sv
// Types and screen geometry shared by the game state engine and the graphics driver.
package pong_pkg;

   localparam int PONG_HEIGHT_COUNTER_SIZE = 9;
   localparam int PONG_WIDTH_COUNTER_SIZE  = 10;
   localparam int PONG_PADDLE_1_X          = 32;
   localparam int PONG_PADDLE_2_X          = 600;
   localparam int PONG_PADDLE_Y            = 200;
   localparam int PONG_BALL_X              = 316;
   localparam int PONG_BALL_Y              = 236;
   localparam int PONG_PADDLE_WIDTH        = 8;
   localparam int PONG_PADDLE_HEIGHT       = 80;
   localparam int PONG_BALL_SIDE_SIZE      = 8;
   localparam int PONG_BORDER_PIXEL_WIDTH  = 8;
   localparam int PONG_SCREEN_WIDTH        = 640;
   localparam int PONG_SCREEN_HEIGHT       = 480;
   localparam int PONG_PADDLE_SPEED        = 4;
   localparam int PONG_BALL_SPEED          = 2;
   localparam int PONG_SERVE_DELAY_FRAMES  = 60;
   localparam int PONG_SCORE_WIDTH         = 4;

   typedef enum logic [1:0] {SERVE, PLAY, SCORED} game_state_t;
   typedef enum logic {DIR_NEG, DIR_POS} dir_t;

endpackage

// File: rtl/game_state_engine_paddle_mover.sv
// One paddle: steps by SPEED on each frame tick and clamps to the playfield.
module paddle_mover #(
   parameter int POS_W    = 10,
   parameter int INIT_POS = 200,
   parameter int SPEED    = 4,
   parameter int MIN_POS  = 8,
   parameter int MAX_POS  = 392
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             up,
   input  logic             down,
   output logic [POS_W-1:0] pos
);

   localparam int SW = POS_W + 2;
   localparam logic signed [SW-1:0] L_SPEED = SW'(SPEED);
   localparam logic signed [SW-1:0] L_MIN   = SW'(MIN_POS);
   localparam logic signed [SW-1:0] L_MAX   = SW'(MAX_POS);
   localparam logic [POS_W-1:0] INIT_V = POS_W'(INIT_POS);
   localparam logic [POS_W-1:0] MIN_V  = POS_W'(MIN_POS);
   localparam logic [POS_W-1:0] MAX_V  = POS_W'(MAX_POS);

   logic [POS_W-1:0]     r_pos;
   logic signed [SW-1:0] w_cur;
   logic signed [SW-1:0] w_step;

   // Two headroom bits keep a step past zero negative instead of wrapping high.
   always_comb begin
      w_cur  = $signed({2'b00, r_pos});
      w_step = w_cur;
      if (up && !down)
         w_step = w_cur - L_SPEED;
      else if (down && !up)
         w_step = w_cur + L_SPEED;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pos <= INIT_V;
      end else if (frame_tick) begin
         if (w_step < L_MIN)
            r_pos <= MIN_V;
         else if (w_step > L_MAX)
            r_pos <= MAX_V;
         else
            r_pos <= w_step[POS_W-1:0];
      end
   end

   assign pos = r_pos;

endmodule

// File: rtl/game_state_engine.sv
// Pong game state: paddles, ball motion, collisions and scoring, advanced once per frame tick.
module game_state_engine
   import pong_pkg::*;
#(
   parameter int HEIGHT_COUNTER_SIZE = PONG_HEIGHT_COUNTER_SIZE,
   parameter int WIDTH_COUNTER_SIZE  = PONG_WIDTH_COUNTER_SIZE,
   parameter int INITIAL_PADDLE_1_X  = PONG_PADDLE_1_X,
   parameter int INITIAL_PADDLE_2_X  = PONG_PADDLE_2_X,
   parameter int INITIAL_PADDLE_Y    = PONG_PADDLE_Y,
   parameter int INITIAL_BALL_X      = PONG_BALL_X,
   parameter int INITIAL_BALL_Y      = PONG_BALL_Y,
   parameter int PADDLE_WIDTH        = PONG_PADDLE_WIDTH,
   parameter int PADDLE_HEIGHT       = PONG_PADDLE_HEIGHT,
   parameter int BALL_SIDE_SIZE      = PONG_BALL_SIDE_SIZE,
   parameter int BORDER_PIXEL_WIDTH  = PONG_BORDER_PIXEL_WIDTH,
   parameter int SCREEN_WIDTH        = PONG_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT       = PONG_SCREEN_HEIGHT,
   parameter int PADDLE_SPEED        = PONG_PADDLE_SPEED,
   parameter int BALL_SPEED          = PONG_BALL_SPEED,
   parameter int SERVE_DELAY_FRAMES  = PONG_SERVE_DELAY_FRAMES,
   parameter int SCORE_WIDTH         = PONG_SCORE_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame_tick,
   input  logic                          p1_up,
   input  logic                          p1_down,
   input  logic                          p2_up,
   input  logic                          p2_down,
   output logic [HEIGHT_COUNTER_SIZE:0]  paddle_1_pos,
   output logic [HEIGHT_COUNTER_SIZE:0]  paddle_2_pos,
   output logic [WIDTH_COUNTER_SIZE:0]   ball_pos_x,
   output logic [HEIGHT_COUNTER_SIZE:0]  ball_pos_y,
   output logic [SCORE_WIDTH-1:0]        score_1,
   output logic [SCORE_WIDTH-1:0]        score_2,
   output logic                          point_scored
);

   localparam int XW = WIDTH_COUNTER_SIZE + 1;
   localparam int YW = HEIGHT_COUNTER_SIZE + 1;
   localparam int SW = ((XW > YW) ? XW : YW) + 2;
   localparam int CW = (SERVE_DELAY_FRAMES > 2) ? $clog2(SERVE_DELAY_FRAMES) : 1;

   localparam logic signed [SW-1:0] L_SPD    = SW'(BALL_SPEED);
   localparam logic signed [SW-1:0] L_BALL   = SW'(BALL_SIDE_SIZE);
   localparam logic signed [SW-1:0] L_BORDER = SW'(BORDER_PIXEL_WIDTH);
   localparam logic signed [SW-1:0] L_BOTTOM = SW'(SCREEN_HEIGHT - BORDER_PIXEL_WIDTH);
   localparam logic signed [SW-1:0] L_RIGHT  = SW'(SCREEN_WIDTH - BORDER_PIXEL_WIDTH);
   localparam logic signed [SW-1:0] L_P1_L   = SW'(INITIAL_PADDLE_1_X);
   localparam logic signed [SW-1:0] L_P1_R   = SW'(INITIAL_PADDLE_1_X + PADDLE_WIDTH);
   localparam logic signed [SW-1:0] L_P2_L   = SW'(INITIAL_PADDLE_2_X);
   localparam logic signed [SW-1:0] L_P2_R   = SW'(INITIAL_PADDLE_2_X + PADDLE_WIDTH);
   localparam logic signed [SW-1:0] L_PH     = SW'(PADDLE_HEIGHT);

   localparam logic [XW-1:0] BALL_X0     = XW'(INITIAL_BALL_X);
   localparam logic [YW-1:0] BALL_Y0     = YW'(INITIAL_BALL_Y);
   localparam logic [YW-1:0] TOP_Y       = YW'(BORDER_PIXEL_WIDTH);
   localparam logic [YW-1:0] BOT_Y       = YW'(SCREEN_HEIGHT - 2*BORDER_PIXEL_WIDTH - BALL_SIDE_SIZE);
   localparam logic [XW-1:0] P1_BOUNCE_X = XW'(INITIAL_PADDLE_1_X + PADDLE_WIDTH);
   localparam logic [XW-1:0] P2_BOUNCE_X = XW'(INITIAL_PADDLE_2_X - BALL_SIDE_SIZE);
   localparam logic [CW-1:0] CNT_LAST    = CW'(SERVE_DELAY_FRAMES - 1);

   game_state_t          r_state;
   logic [CW-1:0]        r_cnt;
   logic [XW-1:0]        r_ball_x;
   logic [YW-1:0]        r_ball_y;
   dir_t                 r_dx;
   dir_t                 r_dy;
   logic [SCORE_WIDTH-1:0] r_score_1;
   logic [SCORE_WIDTH-1:0] r_score_2;
   logic                 r_point;

   logic signed [SW-1:0] w_cand_x, w_cand_y, w_p1_y, w_p2_y;
   logic w_top, w_bot, w_miss_l, w_miss_r, w_hit_p1, w_hit_p2;

   function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] s);
      return (&s) ? s : s + 1'b1;
   endfunction

   paddle_mover #(
      .POS_W(YW), .INIT_POS(INITIAL_PADDLE_Y), .SPEED(PADDLE_SPEED),
      .MIN_POS(BORDER_PIXEL_WIDTH), .MAX_POS(SCREEN_HEIGHT - BORDER_PIXEL_WIDTH - PADDLE_HEIGHT)
   ) u_paddle_1 (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .up(p1_up), .down(p1_down), .pos(paddle_1_pos)
   );

   paddle_mover #(
      .POS_W(YW), .INIT_POS(INITIAL_PADDLE_Y), .SPEED(PADDLE_SPEED),
      .MIN_POS(BORDER_PIXEL_WIDTH), .MAX_POS(SCREEN_HEIGHT - BORDER_PIXEL_WIDTH - PADDLE_HEIGHT)
   ) u_paddle_2 (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .up(p2_up), .down(p2_down), .pos(paddle_2_pos)
   );

   // Collisions are judged on the candidate position against the paddles as they were before this tick.
   assign w_cand_x = (r_dx == DIR_POS) ? $signed({{(SW-XW){1'b0}}, r_ball_x}) + L_SPD
                                       : $signed({{(SW-XW){1'b0}}, r_ball_x}) - L_SPD;
   assign w_cand_y = (r_dy == DIR_POS) ? $signed({{(SW-YW){1'b0}}, r_ball_y}) + L_SPD
                                       : $signed({{(SW-YW){1'b0}}, r_ball_y}) - L_SPD;
   assign w_p1_y   = $signed({{(SW-YW){1'b0}}, paddle_1_pos});
   assign w_p2_y   = $signed({{(SW-YW){1'b0}}, paddle_2_pos});

   assign w_top    = (w_cand_y <= L_BORDER);
   assign w_bot    = (w_cand_y + L_BALL >= L_BOTTOM);
   assign w_miss_l = (w_cand_x <= L_BORDER);
   assign w_miss_r = (w_cand_x + L_BALL >= L_RIGHT);
   assign w_hit_p1 = !w_miss_l && !w_miss_r && (r_dx == DIR_NEG)
                     && (w_cand_x < L_P1_R) && (w_cand_x + L_BALL > L_P1_L)
                     && (w_cand_y < w_p1_y + L_PH) && (w_cand_y + L_BALL > w_p1_y);
   assign w_hit_p2 = !w_miss_l && !w_miss_r && (r_dx == DIR_POS)
                     && (w_cand_x < L_P2_R) && (w_cand_x + L_BALL > L_P2_L)
                     && (w_cand_y < w_p2_y + L_PH) && (w_cand_y + L_BALL > w_p2_y);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SERVE;
         r_cnt     <= '0;
         r_ball_x  <= BALL_X0;
         r_ball_y  <= BALL_Y0;
         r_dx      <= DIR_POS;
         r_dy      <= DIR_POS;
         r_score_1 <= '0;
         r_score_2 <= '0;
         r_point   <= 1'b0;
      end else begin
         r_point <= 1'b0;
         case (r_state)
            SERVE: begin
               if (frame_tick) begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt   <= '0;
                     r_state <= PLAY;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (w_top) begin
                     r_ball_y <= TOP_Y;
                     r_dy     <= DIR_POS;
                  end else if (w_bot) begin
                     r_ball_y <= BOT_Y;
                     r_dy     <= DIR_NEG;
                  end else begin
                     r_ball_y <= w_cand_y[YW-1:0];
                  end
                  if (w_hit_p1) begin
                     r_ball_x <= P1_BOUNCE_X;
                     r_dx     <= DIR_POS;
                  end else if (w_hit_p2) begin
                     r_ball_x <= P2_BOUNCE_X;
                     r_dx     <= DIR_NEG;
                  end else begin
                     r_ball_x <= w_cand_x[XW-1:0];
                  end
                  if (w_miss_l) begin
                     r_score_2 <= sat_inc(r_score_2);
                     r_state   <= SCORED;
                  end else if (w_miss_r) begin
                     r_score_1 <= sat_inc(r_score_1);
                     r_state   <= SCORED;
                  end
               end
            end
            SCORED: begin
               // The ball still sits on the side it left through, which names the conceding player.
               r_dx     <= (r_ball_x < BALL_X0) ? DIR_NEG : DIR_POS;
               r_point  <= 1'b1;
               r_ball_x <= BALL_X0;
               r_ball_y <= BALL_Y0;
               r_state  <= SERVE;
            end
            default: r_state <= SERVE;
         endcase
      end
   end

   assign ball_pos_x   = r_ball_x;
   assign ball_pos_y   = r_ball_y;
   assign score_1      = r_score_1;
   assign score_2      = r_score_2;
   assign point_scored = r_point;

endmodule

// File: tb/tb_game_state_engine.sv
// Randomized scoreboard bench for game_state_engine against a frame-level reference model.
module tb_game_state_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0, frame_tick = 1'b0;
   logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
   logic [9:0]  paddle_1_pos, paddle_2_pos, ball_pos_y;
   logic [10:0] ball_pos_x;
   logic [3:0]  score_1, score_2;
   logic        point_scored;

   game_state_engine dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .paddle_1_pos(paddle_1_pos), .paddle_2_pos(paddle_2_pos),
      .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
      .score_1(score_1), .score_2(score_2), .point_scored(point_scored)
   );

   // off = clock edges after the rst/tick edge at which this snapshot must be visible
   typedef struct { int off; int p1; int p2; int bx; int by; int s1; int s2; int ps; } exp_t;
   exp_t q[$];
   exp_t last;
   int checks = 0, errors = 0;
   bit armed = 1'b0;
   int since = 0;

   // Reference model state: plain integers, directions as +1/-1
   int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_serve;
   bit m_play;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input exp_t e, input string tag);
      chk({tag, ".paddle_1_pos"}, int'(paddle_1_pos), e.p1);
      chk({tag, ".paddle_2_pos"}, int'(paddle_2_pos), e.p2);
      chk({tag, ".ball_pos_x"},   int'(ball_pos_x),   e.bx);
      chk({tag, ".ball_pos_y"},   int'(ball_pos_y),   e.by);
      chk({tag, ".score_1"},      int'(score_1),      e.s1);
      chk({tag, ".score_2"},      int'(score_2),      e.s2);
      chk({tag, ".point_scored"}, int'(point_scored), e.ps);
   endtask

   function automatic exp_t snap(input int off, input int ps);
      exp_t e;
      e.off = off; e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
      e.s1 = m_s1; e.s2 = m_s2; e.ps = ps;
      return e;
   endfunction

   function automatic int move_paddle(input int p, input logic up, input logic dn);
      int n = p;
      if (up && !dn) n = p - 4;
      else if (dn && !up) n = p + 4;
      if (n < 8) n = 8;
      if (n > 392) n = 392;
      return n;
   endfunction

   function automatic bit overlaps(input int cx, input int cy, input int px, input int py);
      return (cx < px + 8) && (cx + 8 > px) && (cy < py + 80) && (cy + 8 > py);
   endfunction

   task automatic model_reset();
      m_p1 = 200; m_p2 = 200; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
      m_s1 = 0; m_s2 = 0; m_serve = 0; m_play = 1'b0;
   endtask

   task automatic model_tick(input logic [3:0] b);
      int np1, np2, cx, cy, nx, ny, side;
      bit scored;
      scored = 1'b0; side = 0;
      np1 = move_paddle(m_p1, b[3], b[2]);
      np2 = move_paddle(m_p2, b[1], b[0]);
      if (!m_play) begin
         m_serve++;
         if (m_serve == 60) begin m_serve = 0; m_play = 1'b1; end
      end else begin
         cx = m_bx + 2 * m_dx;
         cy = m_by + 2 * m_dy;
         nx = cx; ny = cy;
         if (cy <= 8) begin ny = 8; m_dy = 1; end
         else if (cy + 8 >= 472) begin ny = 456; m_dy = -1; end
         if (cx <= 8) begin
            scored = 1'b1; side = -1; if (m_s2 < 15) m_s2++;
         end else if (cx + 8 >= 632) begin
            scored = 1'b1; side = 1; if (m_s1 < 15) m_s1++;
         end else if (m_dx == -1 && overlaps(cx, cy, 32, m_p1)) begin
            nx = 40; m_dx = 1;
         end else if (m_dx == 1 && overlaps(cx, cy, 600, m_p2)) begin
            nx = 592; m_dx = -1;
         end
         m_bx = nx; m_by = ny;
      end
      m_p1 = np1; m_p2 = np2;
      q.push_back(snap(1, 0));
      if (scored) begin
         m_bx = 316; m_by = 236; m_dx = side; m_play = 1'b0; m_serve = 0;
         q.push_back(snap(2, 1));
      end
   endtask

   // One clock: drive inputs just after the falling edge and predict the next rising edge.
   task automatic do_cycle(input logic r, input logic t, input logic [3:0] b);
      @(negedge clk); #1;
      rst = r; frame_tick = t;
      {p1_up, p1_down, p2_up, p2_down} = b;
      if (r) begin
         model_reset();
         q.push_back(snap(1, 0));
      end else if (t) begin
         model_tick(b);
      end
   endtask

   task automatic tick(input logic [3:0] b);
      do_cycle(1'b0, 1'b1, b);
      for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, b);
   endtask

   function automatic logic [1:0] track(input int pad, input int by);
      if (pad + 40 > by + 6) return 2'b10;
      if (pad + 40 < by + 2) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [1:0] away(input int by);
      return (by >= 236) ? 2'b10 : 2'b01;
   endfunction

   // Monitor: every cycle either the due scoreboard entry or the held previous outputs must show.
   initial begin
      forever begin
         @(posedge clk);
         if (rst === 1'b1) begin since = 1; armed = 1'b1; end
         else if (frame_tick === 1'b1) since = 1;
         else since = since + 1;
         @(negedge clk);
         if (armed) begin
            if (q.size() > 0 && q[0].off == since) begin
               last = q.pop_front();
               check_all(last, "update");
               last.ps = 0;
            end else begin
               check_all(last, "hold");
            end
         end
      end
   end

   initial begin
      int target;
      model_reset();
      do_cycle(1'b1, 1'b0, 4'b0000);
      do_cycle(1'b1, 1'b1, 4'b1010);
      do_cycle(1'b0, 1'b0, 4'b0000);

      // Serve: p1 climbs to the top border, p2 descends to the bottom clamp, then both buttons held.
      for (int i = 0; i < 50; i++) tick(4'b1001);
      for (int i = 0; i < 9; i++) tick(4'b1111);
      tick(4'b0000);
      for (int i = 0; i < 3; i++) tick(4'b0000);

      for (int i = 0; i < 1200; i++) tick({track(m_p1, m_by), track(m_p2, m_by)});
      for (int i = 0; i < 2500 && m_s2 < 3; i++) tick({away(m_by), track(m_p2, m_by)});
      for (int i = 0; i < 6000 && m_s1 < 15; i++) tick({track(m_p1, m_by), away(m_by)});
      target = m_s1;
      for (int i = 0; i < 600; i++) tick({track(m_p1, m_by), away(m_by)});
      for (int i = 0; i < 1000; i++) tick(4'($urandom_range(0, 15)));

      for (int i = 0; i < 200 && !m_play; i++) tick(4'b0000);
      for (int i = 0; i < 5; i++) tick(4'b0110);
      do_cycle(1'b1, 1'b1, 4'b1010);
      do_cycle(1'b0, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) tick(4'($urandom_range(0, 15)));
      for (int k = 0; k < 4; k++) do_cycle(1'b0, 1'b0, 4'b0000);

      chk("score_1_reached_saturation", target, 15);
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
